// File: rtl/bp_update_queue_pkg.sv
// Shared types for the branch-prediction update queue: the per-branch record
// and the helpers that turn a stored record into the chooser's view of it.
package bp_update_queue_pkg;

    localparam int LC3B_WORD_W = 16;
    typedef logic [LC3B_WORD_W-1:0] lc3b_word;

    typedef struct packed {
        lc3b_word pc;
        logic     lp;
        logic     gp;
        logic     ch;
    } bp_entry_t;

    localparam logic BP_CHOICE_LOCAL  = 1'b0;
    localparam logic BP_CHOICE_GLOBAL = 1'b1;

    function automatic logic bp_final_pred(input bp_entry_t e);
        return (e.ch == BP_CHOICE_GLOBAL) ? e.gp : e.lp;
    endfunction

    function automatic logic bp_unchosen_pred(input bp_entry_t e);
        return (e.ch == BP_CHOICE_LOCAL) ? e.gp : e.lp;
    endfunction

endpackage

// File: rtl/bp_update_queue_if.sv
// Fetch/execute-side bundle of the update queue: allocation, resolution,
// squash and the registered chooser-training outputs.
interface bp_update_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             alloc_valid;
    logic [PC_W-1:0]  alloc_pc;
    logic             alloc_local_pred;
    logic             alloc_global_pred;
    logic             alloc_choice;
    logic             alloc_ready;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             squash;
    logic             upd_write;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic             upd_control_flush;
    logic             upd_unchosen_pred;
    logic             redirect;
    logic [CNT_W-1:0] count;
    logic             err;

    modport master (
        output alloc_valid, alloc_pc, alloc_local_pred, alloc_global_pred, alloc_choice,
        output resolve_valid, resolve_taken, squash,
        input  alloc_ready, upd_write, upd_pc, upd_taken, upd_control_flush,
        input  upd_unchosen_pred, redirect, count, err
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_local_pred, alloc_global_pred, alloc_choice,
        input  resolve_valid, resolve_taken, squash,
        output alloc_ready, upd_write, upd_pc, upd_taken, upd_control_flush,
        output upd_unchosen_pred, redirect, count, err
    );
endinterface

// File: rtl/bp_update_queue_storage.sv
// DEPTH-entry register array for in-flight branch records: one write port,
// one combinational read port (driven with the head pointer).
module bp_update_queue_storage
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  bp_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output bp_entry_t        rd_data
);

    bp_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/bp_update_queue.sv
// In-order branch tracking queue: records predictions at fetch, trains the
// tournament chooser one cycle after each resolve, flushes wrong-path entries.
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    bp_update_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    bp_entry_t        head_e, wr_e;

    logic             vld_p1, taken_p1, flush_p1, unchosen_p1;
    logic [PC_W-1:0]  pc_p1;

    logic empty, do_res, mis, flush, do_push, err_set;

    assign empty   = (cnt == '0);
    assign do_res  = q.resolve_valid && !empty;
    assign mis     = do_res && (bp_final_pred(head_e) != q.resolve_taken);
    // Any flush (external or mispredict) makes a same-cycle alloc wrong-path, not an error.
    assign flush   = q.squash || mis;
    assign do_push = q.alloc_valid && q.alloc_ready && !flush;
    assign err_set = (q.resolve_valid && empty) ||
                     (q.alloc_valid && !q.alloc_ready && !flush);

    assign wr_e.pc = lc3b_word'(q.alloc_pc);
    assign wr_e.lp = q.alloc_local_pred;
    assign wr_e.gp = q.alloc_global_pred;
    assign wr_e.ch = q.alloc_choice;

    bp_update_queue_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_ptr  (tail),
        .wr_data (wr_e),
        .rd_ptr  (head),
        .rd_data (head_e)
    );

    // Queue control
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (flush) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (do_push) begin
                    tail <= tail + PTR_W'(1);
                end
                if (do_res) begin
                    head <= head + PTR_W'(1);
                end
                cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_res);
            end
        end
    end

    // Stage p1: registered chooser-training outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            taken_p1    <= 1'b0;
            flush_p1    <= 1'b0;
            unchosen_p1 <= 1'b0;
        end else begin
            vld_p1 <= do_res;
            if (do_res) begin
                pc_p1       <= PC_W'(head_e.pc);
                taken_p1    <= q.resolve_taken;
                flush_p1    <= mis;
                unchosen_p1 <= bp_unchosen_pred(head_e);
            end
        end
    end

    assign q.alloc_ready       = (cnt != FULL);
    assign q.count             = cnt;
    assign q.err               = err_q;
    assign q.upd_write         = vld_p1;
    assign q.upd_pc            = pc_p1;
    assign q.upd_taken         = taken_p1;
    assign q.upd_control_flush = flush_p1;
    assign q.upd_unchosen_pred = unchosen_p1;
    assign q.redirect          = vld_p1 && flush_p1;

endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- In-order tracking queue for conditional-branch predictions between fetch and execute.
- At fetch it records each branch's PC, local-predictor bit, global-predictor bit and tournament chooser pick.
- At resolve it pops the oldest entry and drives the chooser's training interface one cycle later: write, write_pc, taken, control_flush, unchosen_pred.
- A mispredict squashes all younger (wrong-path) entries.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, minimum 2.
- PC_W, 16, width of lc3b_word PC.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  fetch pushes one predicted branch this cycle.
- alloc_pc  in  PC_W  PC of the pushed branch.
- alloc_local_pred  in  1  local predictor direction (1 = taken).
- alloc_global_pred  in  1  global predictor direction.
- alloc_choice  in  1  chooser pick: 0 = local, 1 = global.
- alloc_ready  out  1  queue not full; combinational from count.
- resolve_valid  in  1  execute resolves the oldest in-flight branch.
- resolve_taken  in  1  actual direction.
- squash  in  1  external pipeline flush (trap/interrupt); drops all entries without training.
- upd_write  out  1  one-cycle pulse to chooser write.
- upd_pc  out  PC_W  to chooser write_pc.
- upd_taken  out  1  to chooser taken.
- upd_control_flush  out  1  final prediction was wrong.
- upd_unchosen_pred  out  1  direction of the predictor not selected.
- redirect  out  1  one-cycle pulse, equals upd_write & upd_control_flush.
- count  out  log2(DEPTH)+1  current occupancy.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, reset_n low):
  - head, tail and count = 0.
  - upd_write, upd_pc, upd_taken, upd_control_flush, upd_unchosen_pred, redirect and err = 0.
  - Entry storage need not reset.
  - Reset mid-operation discards all entries; no update is issued.
- Storage: circular buffer of DEPTH entries {pc, lp, gp, ch}. Head and tail pointers wrap modulo DEPTH; count is tracked separately so full and empty are distinguishable.
- alloc_ready = (count != DEPTH). Does not depend on resolve_valid in the same cycle.
- Allocate: when alloc_valid && alloc_ready, write the entry at tail, then tail+1 and count+1.
- Allocate while full: the push is dropped and err is set.
- Resolve, when resolve_valid && count != 0, reading the head entry e:
  - final = e.ch ? e.gp : e.lp.
  - unchosen = e.ch ? e.lp : e.gp.
  - mis = (final != resolve_taken).
  - Registered next cycle: upd_write = 1, upd_pc = e.pc, upd_taken = resolve_taken, upd_control_flush = mis, upd_unchosen_pred = unchosen, redirect = mis.
  - Latency is exactly 1 cycle from the resolve edge to the upd_* outputs.
  - upd_write is low in every cycle that is not one cycle after a valid resolve.
  - Correct prediction: head+1, count-1.
  - Mispredict: all entries are discarded (everything younger is wrong-path). head = tail = 0, count = 0.
- Resolve while empty: ignored, no update, err set.
- Simultaneous alloc and correct resolve: both apply; count unchanged. If count == DEPTH, the alloc is dropped per alloc_ready and err is set.
- Simultaneous alloc and mispredicting resolve: the alloc is discarded as wrong-path and err is not set; the queue ends empty.
- Squash without resolve: queue cleared, no update pulse.
- Squash with resolve: the resolve is processed first, so the update is emitted normally with mis computed as above. The queue then ends empty regardless of mis, and any same-cycle alloc is dropped without setting err.
- err is cleared only by reset.
- No combinational path from any input to the upd_* or redirect outputs.

Decomposition:
- lc3b_types additions:
  - bp_entry_t packed struct {lc3b_word pc; logic lp; logic gp; logic ch;}.
  - Constants BP_CHOICE_LOCAL = 1'b0 and BP_CHOICE_GLOBAL = 1'b1.
- One natural sub-module: bp_queue_storage, a DEPTH x bp_entry_t register array with one write port and one combinational read port at head. Pointer, count and flush control stay in the top.

Test Plan:
1. Reset then idle:
   - Hold reset_n = 0 for 2 cycles, then release.
   - Required: count = 0, alloc_ready = 1, upd_write = 0, err = 0 for 10 cycles.
2. Correct prediction via global:
   - Alloc pc = 0x1234, lp = 0, gp = 1, ch = 1; next cycle resolve taken = 1.
   - One cycle later: upd_write = 1, upd_pc = 0x1234, upd_taken = 1, upd_control_flush = 0, upd_unchosen_pred = 0, redirect = 0, count = 0.
3. Mispredict flush:
   - Alloc 3 entries: A = 0x0100 (lp = 1, gp = 0, ch = 0), B = 0x0102, C = 0x0104. Resolve A with taken = 0.
   - Required: upd_control_flush = 1, upd_unchosen_pred = 0, redirect = 1, count = 0.
   - A following resolve gives no update and sets err.
4. Full/wrap:
   - Alloc 4 entries (0x0010..0x0016); alloc_ready = 0.
   - A 5th alloc sets err.
   - Resolve all 4 correctly, then alloc 4 more. Pointers wrap; updates emerge in order 0x0010, 0x0012, 0x0014, 0x0016.
5. Simultaneous alloc and correct resolve at count = 2:
   - count stays 2, FIFO order is preserved, err = 0.
6. Squash with resolve and pending alloc:
   - count = 3; same cycle resolve (correct), squash = 1, alloc_valid = 1.
   - Update pulse emitted with upd_control_flush = 0; count = 0; err = 0.
   - Then assert reset_n = 0 mid-pulse: upd_write drops immediately.
